game_mem_ctrl: RTL and testbench
================================

// Module: game_mem_ctrl
// PURPOSE
//  Parametrised successor to the game memory: a per-entry valid-tracked store for game
//  values, with a registered read port and a one-cycle bulk clear. Adds occupancy/full/empty
//  status and a sequential key-search engine returning the first matching index.
//  Sits between game control FSM (writes/clears/searches) and scoring/display (reads).
// PARAMETERS
//  ENTRIES     16  number of storage entries, 1 <= ENTRIES <= 2**ADDR_WIDTH
//  ADDR_WIDTH   4  address / index width
//  DATA_WIDTH   8  stored value width
//  CNT_WIDTH    5  occupancy counter width, must hold ENTRIES (ADDR_WIDTH+1)
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rstn       in   1           asynchronous active-low reset
//  wr_en      in   1           write strobe
//  wr_addr    in   ADDR_WIDTH  write address
//  wr_data    in   DATA_WIDTH  write data
//  rd_en      in   1           read strobe
//  rd_addr    in   ADDR_WIDTH  read address
//  rd_data    out  DATA_WIDTH  registered read data, 0 when entry invalid
//  rd_vld     out  1           pulse: rd_data valid, one cycle after rd_en
//  rd_hit     out  1           entry was valid at read time (qualifies rd_data)
//  clr_all    in   1           clear every valid bit
//  srch_start in   1           start search for srch_key
//  srch_key   in   DATA_WIDTH  search key, latched on accepted start
//  srch_busy  out  1           search in progress (SCAN)
//  srch_done  out  1           one-cycle pulse: search finished
//  srch_hit   out  1           last search found a valid match
//  srch_idx   out  ADDR_WIDTH  index of first match (0 on miss)
//  occupancy  out  CNT_WIDTH   number of valid entries
//  full       out  1           occupancy == ENTRIES
//  empty      out  1           occupancy == 0
// BEHAVIOUR
//  Reset (async, rstn=0): valid bits, occupancy, rd_*, srch_* outputs, FSM -> 0/IDLE;
//   empty=1. Data array not reset.
//  Write: wr_en && wr_addr<ENTRIES -> mem<=wr_data, valid<=1; occupancy +1 only if entry
//   was invalid. wr_addr>=ENTRIES ignored.
//  Read: rd_en sampled at edge N -> rd_vld=1 after N, rd_data=mem or 0, rd_hit=valid.
//   Read-before-write: same-cycle write to rd_addr returns the OLD value/valid.
//   rd_addr>=ENTRIES -> rd_data=0, rd_hit=0. rd_data/rd_hit hold until next read.
//  Clear: clr_all -> all valid<=0, occupancy<=0 at next edge. clr_all beats wr_en in the
//   same cycle (write dropped). Data array untouched.
//  Search FSM IDLE -> SCAN -> DONE -> IDLE:
//   IDLE: srch_start latches key, idx<=0, -> SCAN. Start while not IDLE is ignored.
//   SCAN: each edge compares entry idx (current contents, incl. writes already committed);
//    valid && match -> DONE, srch_hit<=1, srch_idx<=idx; idx==ENTRIES-1 no match -> DONE,
//    hit<=0, idx<=0; else idx+1. Match at k: srch_done high k+1 cycles after start edge;
//    full miss: ENTRIES cycles after.
//   DONE: srch_done=1 for exactly one cycle, -> IDLE. srch_hit/idx hold until next start.
//   clr_all during SCAN aborts: -> DONE with hit=0, idx=0.
//  full/empty combinational from occupancy. No output depends combinationally on inputs.
// STRUCTURE
//  game_pkg: search state encoding (IDLE/SCAN/DONE), default width localparams.
//  Sub-module game_mem_scan: search FSM + index counter; takes valid vector and
//   element-at-idx data, returns busy/done/hit/idx. Storage, valid, occupancy in top.
// TESTING
//  Reset then read addr 5 -> rd_vld=1, rd_hit=0, rd_data=0; empty=1, occupancy=0.
//  Write 0xA5@3, 0x3C@7, rewrite 0x11@3 -> occupancy=2; read 3 -> 0x11, rd_hit=1.
//  Write 0x42@2 + read 2 same cycle -> rd_data=0, rd_hit=0; next read -> 0x42.
//  Key 0x3C stored @7 -> srch_done 8 cycles after start, hit=1, idx=7; key 0x99 -> done
//   after 16 cycles, hit=0, idx=0; start during SCAN ignored.
//  Fill all 16 -> full=1; clr_all+wr_en same cycle -> occupancy=0, empty=1, reads miss.
//  clr_all mid-SCAN -> done next cycle, hit=0; rstn low mid-scan -> busy/done/hit=0 at once.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default sizes for the game memory controller.
package game_pkg;

  localparam int ENTRIES_D = 16;
  localparam int ADDR_W_D  = 4;
  localparam int DATA_W_D  = 8;
  localparam int CNT_W_D   = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } srch_st_e;

endpackage

// File: rtl/game_mem_scan.sv
// Sequential key search: walks the entries one per cycle
// and reports the first valid match.
module game_mem_scan #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] key,
  input  logic [ENTRIES-1:0]    valid,
  input  logic [DATA_WIDTH-1:0] cur_data,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] hit_idx
);
  import game_pkg::*;

  srch_st_e              st, st_n;
  logic [ADDR_WIDTH-1:0] idx_n, hidx_n;
  logic [DATA_WIDTH-1:0] key_q, key_n;
  logic                  hit_n;
  logic                  last;

  assign last = (idx == ADDR_WIDTH'(ENTRIES - 1));
  assign busy = (st == S_SCAN);
  assign done = (st == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st      <= S_IDLE;
      idx     <= '0;
      key_q   <= '0;
      hit     <= 1'b0;
      hit_idx <= '0;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      key_q   <= key_n;
      hit     <= hit_n;
      hit_idx <= hidx_n;
    end
  end

  // A clear during the scan wins over a match seen the same cycle.
  always_comb begin
    st_n   = st;
    idx_n  = idx;
    key_n  = key_q;
    hit_n  = hit;
    hidx_n = hit_idx;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          st_n  = S_SCAN;
          idx_n = '0;
          key_n = key;
        end
      end
      S_SCAN: begin
        if (clr) begin
          st_n   = S_DONE;
          hit_n  = 1'b0;
          hidx_n = '0;
        end else if (valid[idx] && cur_data == key_q) begin
          st_n   = S_DONE;
          hit_n  = 1'b1;
          hidx_n = idx;
        end else if (last) begin
          st_n   = S_DONE;
          hit_n  = 1'b0;
          hidx_n = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

endmodule

// File: rtl/game_mem_ctrl.sv
// Valid-tracked game value store with registered read,
// bulk clear, occupancy status and first-match search.
module game_mem_ctrl
  import game_pkg::*;
#(
  parameter int ENTRIES    = ENTRIES_D,
  parameter int ADDR_WIDTH = ADDR_W_D,
  parameter int DATA_WIDTH = DATA_W_D,
  parameter int CNT_WIDTH  = CNT_W_D
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  output logic                  rd_hit,
  input  logic                  clr_all,
  input  logic                  srch_start,
  input  logic [DATA_WIDTH-1:0] srch_key,
  output logic                  srch_busy,
  output logic                  srch_done,
  output logic                  srch_hit,
  output logic [ADDR_WIDTH-1:0] srch_idx,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [ENTRIES-1:0]    valid;
  logic [ADDR_WIDTH-1:0] scan_idx;
  logic                  wr_in, rd_in, wr_ok;

  assign wr_in = 32'(wr_addr) < ENTRIES;
  assign rd_in = 32'(rd_addr) < ENTRIES;
  assign wr_ok = wr_en && !clr_all && wr_in;

  assign full  = (occupancy == CNT_WIDTH'(ENTRIES));
  assign empty = (occupancy == '0);

  // Data array carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid     <= '0;
      occupancy <= '0;
    end else if (clr_all) begin
      valid     <= '0;
      occupancy <= '0;
    end else if (wr_ok) begin
      valid[wr_addr] <= 1'b1;
      if (!valid[wr_addr]) occupancy <= occupancy + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld  <= 1'b0;
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_in && valid[rd_addr];
        rd_data <= (rd_in && valid[rd_addr]) ? mem[rd_addr] : '0;
      end
    end
  end

  game_mem_scan #(
    .ENTRIES    (ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_scan (
    .clk      (clk),
    .rstn     (rstn),
    .start    (srch_start),
    .clr      (clr_all),
    .key      (srch_key),
    .valid    (valid),
    .cur_data (mem[scan_idx]),
    .idx      (scan_idx),
    .busy     (srch_busy),
    .done     (srch_done),
    .hit      (srch_hit),
    .hit_idx  (srch_idx)
  );

endmodule

// File: tb/tb_game_mem_ctrl.sv
// Bench for game_mem_ctrl: vector table with a read scoreboard,
// plus search, clear and reset sequences.
module tb_game_mem_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en, rd_en, clr_all, srch_start;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, srch_key;
  logic [7:0] rd_data;
  logic       rd_vld, rd_hit;
  logic       srch_busy, srch_done, srch_hit;
  logic [3:0] srch_idx;
  logic [4:0] occupancy;
  logic       full, empty;

  int tests  = 0;
  int errors = 0;

  logic [8:0] sb [$];

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] xd;
    logic       xh;
    logic [4:0] xocc;
  } vec_t;

  vec_t vt [12];

  game_mem_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .rd_hit     (rd_hit),
    .clr_all    (clr_all),
    .srch_start (srch_start),
    .srch_key   (srch_key),
    .srch_busy  (srch_busy),
    .srch_done  (srch_done),
    .srch_hit   (srch_hit),
    .srch_idx   (srch_idx),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one cycle and checks the read result.
  task automatic step(input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [3:0] ra, input logic clr,
                      input logic [7:0] xd, input logic xh);
    logic [8:0] e;
    logic       exp_v;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_all = clr;
    if (re) sb.push_back({xh, xd});
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_all = 1'b0;
    exp_v = (sb.size() > 0);
    chk("rd_vld", rd_vld, exp_v);
    if (exp_v) begin
      e = sb.pop_front();
      chk("rd_data", rd_data, e[7:0]);
      chk("rd_hit", rd_hit, e[8]);
    end
  endtask

  // Returns cycles from the start edge to srch_done; a second start
  // and an optional clear are injected while scanning.
  task automatic search(input logic [7:0] key, input int clr_at,
                        output int n);
    srch_start = 1'b1; srch_key = key;
    @(posedge clk);
    @(negedge clk);
    srch_start = 1'b0;
    n = 0;
    chk("srch_busy_start", srch_busy, 1);
    while (!srch_done && n < 40) begin
      if (n == 3) begin
        srch_start = 1'b1; srch_key = 8'h77;
      end
      if (n == clr_at) clr_all = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
      srch_start = 1'b0; clr_all = 1'b0;
    end
    chk("srch_done_seen", srch_done, 1);
    chk("srch_busy_done", srch_busy, 0);
  endtask

  task automatic done_drops();
    @(posedge clk);
    @(negedge clk);
    chk("srch_done_pulse", srch_done, 0);
    chk("srch_busy_idle", srch_busy, 0);
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h00, 1'b0, 5'd0};
    vt[1]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00, 1'b0, 5'd1};
    vt[2]  = '{1'b1, 4'd7,  8'h3C, 1'b0, 4'd0,  8'h00, 1'b0, 5'd2};
    vt[3]  = '{1'b1, 4'd3,  8'h11, 1'b0, 4'd0,  8'h00, 1'b0, 5'd2};
    vt[4]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'h11, 1'b1, 5'd2};
    vt[5]  = '{1'b1, 4'd2,  8'h42, 1'b1, 4'd2,  8'h00, 1'b0, 5'd3};
    vt[6]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd2,  8'h42, 1'b1, 5'd3};
    vt[7]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  8'h3C, 1'b1, 5'd3};
    vt[8]  = '{1'b1, 4'd15, 8'h55, 1'b1, 4'd15, 8'h00, 1'b0, 5'd4};
    vt[9]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h55, 1'b1, 5'd4};
    vt[10] = '{1'b1, 4'd3,  8'h77, 1'b1, 4'd3,  8'h11, 1'b1, 5'd4};
    vt[11] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'h77, 1'b1, 5'd4};

    rstn = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr_all = 1'b0; srch_start = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; srch_key = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_busy", srch_busy, 0);
    chk("rst_done", srch_done, 0);

    for (int i = 0; i < 12; i++) begin
      step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, 1'b0,
           vt[i].xd, vt[i].xh);
      chk($sformatf("vec%0d_occ", i), occupancy, vt[i].xocc);
    end

    search(8'h3C, -1, n);
    chk("s3c_cycles", n, 8);
    chk("s3c_hit", srch_hit, 1);
    chk("s3c_idx", srch_idx, 7);
    done_drops();
    chk("s3c_hit_hold", srch_hit, 1);

    search(8'h99, -1, n);
    chk("s99_cycles", n, 16);
    chk("s99_hit", srch_hit, 0);
    chk("s99_idx", srch_idx, 0);
    done_drops();

    for (int i = 0; i < 16; i++)
      step(1'b1, 4'(i), 8'(8'hC0 + i), 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    chk("fill_occ", occupancy, 16);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b0, 8'hC9, 1'b1);

    step(1'b1, 4'd4, 8'hAA, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0);
    chk("clr_occ", occupancy, 0);
    chk("clr_empty", empty, 1);
    chk("clr_full", full, 0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 1'b0, 8'h00, 1'b0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b0, 8'h00, 1'b0);

    step(1'b1, 4'd12, 8'hEE, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    chk("ee_occ", occupancy, 1);
    search(8'hEE, -1, n);
    chk("see_cycles", n, 13);
    chk("see_hit", srch_hit, 1);
    chk("see_idx", srch_idx, 12);
    done_drops();

    srch_start = 1'b1; srch_key = 8'h01;
    @(posedge clk);
    @(negedge clk);
    srch_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", srch_busy, 1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", srch_busy, 0);
    chk("arst_done", srch_done, 0);
    chk("arst_hit", srch_hit, 0);
    chk("arst_idx", srch_idx, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_empty", empty, 1);
    @(negedge clk);
    rstn = 1'b1;

    step(1'b1, 4'd12, 8'hEE, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
    search(8'hEE, 3, n);
    chk("sclr_cycles", n, 4);
    chk("sclr_hit", srch_hit, 0);
    chk("sclr_idx", srch_idx, 0);
    chk("sclr_occ", occupancy, 0);
    done_drops();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
